// File: rtl/uk_table_loader_pkg.sv
// Shared types and constants for the Uk-family table loader.
package uk_pkg;

  // Loader frame-parsing states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_CNT  = 3'd2,
    DATA     = 3'd3,
    GET_CHK  = 3'd4,
    STATUS   = 3'd5
  } uk_state_t;

  localparam logic [7:0]  UK_SYNC_BYTE = 8'hA5;
  localparam int unsigned UK_DEPTH     = 256;
  localparam int unsigned UK_AW        = 8;
  localparam int unsigned UK_DW        = 8;

endpackage

// File: rtl/uk_table_loader_timeout.sv
// Mid-frame idle counter: counts stalled cycles, clears on any transfer,
// flags the cycle in which the TIMEOUT-th consecutive stall occurs.
module uk_loader_timeout #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TO_W    = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_clr,
  output logic o_tc
);

  localparam logic [TO_W-1:0] LP_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_cnt;

  assign o_tc = i_run && (r_cnt == LP_LAST);

  // Count stalled cycles; restart on a transfer, outside a frame, or at terminal count
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uk_table_loader.sv
// Framed byte-stream loader for the writable 256x8 Uk lookup tables.
// Frame: SYNC, ADDR, CNT (0 = 256), CNT data bytes, CHK (sum mod 256).
module uk_table_loader
  import uk_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = UK_SYNC_BYTE,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned TO_W      = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [UK_DW-1:0]     in_data,
  output logic                 in_ready,
  output logic                 tbl_we,
  output logic [UK_AW-1:0]     tbl_addr,
  output logic [UK_DW-1:0]     tbl_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [8:0]           words_written
);

  uk_state_t        r_state;
  uk_state_t        w_next;
  logic             r_in_ready;
  logic             r_we;
  logic [UK_AW-1:0] r_addr;
  logic [UK_DW-1:0] r_wdata;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [8:0]       r_words;
  logic [UK_AW-1:0] r_ptr;
  logic [8:0]       r_remain;
  logic [7:0]       r_chk;

  logic             w_xfer;
  logic             w_active;
  logic             w_tc;
  logic             w_chk_ok;

  assign w_xfer   = in_valid && r_in_ready;
  assign w_active = (r_state != IDLE) && (r_state != STATUS);
  assign w_chk_ok = (in_data == r_chk);

  uk_loader_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .i_run (w_active && !w_xfer),
    .i_clr (w_xfer || !w_active),
    .o_tc  (w_tc)
  );

  // Next-state decode; a timeout (only possible without a transfer) forces STATUS
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_xfer && (in_data == SYNC_BYTE)) w_next = GET_ADDR;
      GET_ADDR: if (w_xfer) w_next = GET_CNT;
      GET_CNT:  if (w_xfer) w_next = DATA;
      DATA:     if (w_xfer && (r_remain == 9'd1)) w_next = GET_CHK;
      GET_CHK:  if (w_xfer) w_next = STATUS;
      STATUS:   w_next = IDLE;
      default:  w_next = IDLE;
    endcase
    if (w_tc) w_next = STATUS;
  end

  // Frame FSM with registered handshake, write port and status outputs.
  // Flags are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_words    <= '0;
      r_ptr      <= '0;
      r_remain   <= '0;
      r_chk      <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != STATUS);
      r_busy     <= (w_next != IDLE);
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= w_tc;
      case (r_state)
        GET_ADDR: begin
          if (w_xfer) begin
            r_ptr <= in_data;
            r_chk <= in_data;
          end
        end
        GET_CNT: begin
          if (w_xfer) begin
            r_remain <= (in_data == 8'd0) ? 9'(UK_DEPTH) : {1'b0, in_data};
            r_chk    <= r_chk + in_data;
            r_words  <= '0;
          end
        end
        DATA: begin
          if (w_xfer) begin
            r_we     <= 1'b1;
            r_addr   <= r_ptr;
            r_wdata  <= in_data;
            r_ptr    <= r_ptr + 1'b1;
            r_chk    <= r_chk + in_data;
            r_words  <= r_words + 9'd1;
            r_remain <= r_remain - 9'd1;
          end
        end
        GET_CHK: begin
          if (w_xfer) begin
            r_done <= w_chk_ok;
            r_err  <= !w_chk_ok;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign tbl_we        = r_we;
  assign tbl_addr      = r_addr;
  assign tbl_wdata     = r_wdata;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign words_written = r_words;

endmodule

// File: tb/tb_uk_table_loader.sv
// Scoreboard bench for uk_table_loader: the stimulus side computes expected
// table writes and frame status from the frame contents; a monitor compares.
module tb_uk_table_loader;

  localparam int unsigned TIMEOUT = 1024;
  localparam logic [7:0]  SYNC    = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       tbl_we;
  logic [7:0] tbl_addr;
  logic [7:0] tbl_wdata;
  logic       busy;
  logic       done;
  logic       err;
  logic [8:0] words_written;

  uk_table_loader #(
    .SYNC_BYTE (SYNC),
    .TIMEOUT   (TIMEOUT),
    .TO_W      (11)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .tbl_we        (tbl_we),
    .tbl_addr      (tbl_addr),
    .tbl_wdata     (tbl_wdata),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  d;
    int unsigned c;
  } wr_t;

  typedef struct {
    logic        dn;
    logic        er;
    logic [8:0]  words;
    int unsigned c;
  } st_t;

  wr_t wq[$];
  st_t sq[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every write strobe and status pulse must match the next expectation
  logic prev_status = 1'b0;
  always @(negedge clk) begin
    wr_t w;
    st_t s;
    if (prev_status) begin
      check("ready_after_status", {31'd0, in_ready}, 32'd1);
      check("busy_after_status", {31'd0, busy}, 32'd0);
    end
    prev_status = 1'b0;
    if (tbl_we) begin
      if (wq.size() == 0) begin
        check("unexpected_write", {24'd0, tbl_addr}, 32'hFFFF_FFFF);
      end else begin
        w = wq.pop_front();
        check("wr_addr", {24'd0, tbl_addr}, {24'd0, w.a});
        check("wr_data", {24'd0, tbl_wdata}, {24'd0, w.d});
        check("wr_cycle", cyc, w.c);
      end
    end
    if (done || err) begin
      if (sq.size() == 0) begin
        check("unexpected_status", {30'd0, done, err}, 32'd0);
      end else begin
        s = sq.pop_front();
        check("st_done", {31'd0, done}, {31'd0, s.dn});
        check("st_err", {31'd0, err}, {31'd0, s.er});
        check("st_words", {23'd0, words_written}, {23'd0, s.words});
        check("st_cycle", cyc, s.c);
        check("st_ready_low", {31'd0, in_ready}, 32'd0);
        check("st_busy", {31'd0, busy}, 32'd1);
        prev_status = 1'b1;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1);
  end

  function automatic int unsigned rgap(input int unsigned gmax);
    return (gmax == 0) ? 0 : $urandom_range(gmax, 0);
  endfunction

  // Offer one byte after gap idle cycles; acc = edge count at which it transferred
  task automatic send(input logic [7:0] b, input int unsigned gap, output int unsigned acc);
    int unsigned n;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rv_in_ready", {31'd0, in_ready}, 32'd0);
    check("rv_tbl_we", {31'd0, tbl_we}, 32'd0);
    check("rv_tbl_addr", {24'd0, tbl_addr}, 32'd0);
    check("rv_tbl_wdata", {24'd0, tbl_wdata}, 32'd0);
    check("rv_busy", {31'd0, busy}, 32'd0);
    check("rv_done", {31'd0, done}, 32'd0);
    check("rv_err", {31'd0, err}, 32'd0);
    check("rv_words", {23'd0, words_written}, 32'd0);
  endtask

  // Send a whole frame; expectations come from the frame contents alone
  task automatic send_frame(input logic [7:0] addr, input logic [7:0] cnt,
                            input logic [7:0] data[$], input bit good,
                            input int unsigned gmax);
    int unsigned acc;
    int unsigned n;
    logic [7:0]  sum;
    wr_t w;
    st_t s;
    n   = (cnt == 8'd0) ? 256 : int'(cnt);
    sum = addr + cnt;
    send(SYNC, rgap(gmax), acc);
    check("busy_after_sync", {31'd0, busy}, 32'd1);
    send(addr, rgap(gmax), acc);
    send(cnt, rgap(gmax), acc);
    for (int i = 0; i < int'(n); i++) begin
      send(data[i], rgap(gmax), acc);
      w.a = addr + 8'(i);
      w.d = data[i];
      w.c = acc;
      wq.push_back(w);
      sum = sum + data[i];
    end
    send(good ? sum : sum - 8'd1, rgap(gmax), acc);
    s.dn    = good;
    s.er    = !good;
    s.words = 9'(n);
    s.c     = acc;
    sq.push_back(s);
  endtask

  initial begin
    logic [7:0]  d[$];
    int unsigned acc;
    int unsigned n;
    st_t s;
    wr_t w;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;

    // Basic frame at full rate
    d = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h10, 8'd3, d, 1'b1, 0);

    // Address wrap 255 -> 0
    d = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(8'hFE, 8'd4, d, 1'b1, 0);

    // CNT=0 means 256 bytes
    d.delete();
    for (int i = 0; i < 256; i++) d.push_back(8'h02);
    send_frame(8'h37, 8'd0, d, 1'b1, 0);

    // Bad checksum: writes still happen, err instead of done
    d = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h10, 8'd3, d, 1'b0, 0);

    // Garbage in IDLE is discarded
    send(8'h00, 0, acc);
    send(8'hFF, 0, acc);
    @(posedge clk); #1;
    check("garbage_busy", {31'd0, busy}, 32'd0);

    // Mid-frame stall after one data byte
    send(SYNC, 0, acc);
    send(8'h20, 0, acc);
    send(8'd3, 0, acc);
    send(8'h77, 0, acc);
    w.a = 8'h20; w.d = 8'h77; w.c = acc;
    wq.push_back(w);
    s.dn = 1'b0; s.er = 1'b1; s.words = 9'd1; s.c = acc + TIMEOUT;
    sq.push_back(s);
    repeat (TIMEOUT + 4) @(posedge clk);
    #1;
    check("timeout_idle_busy", {31'd0, busy}, 32'd0);

    // Reset in DATA after two writes
    send(SYNC, 0, acc);
    send(8'h40, 0, acc);
    send(8'd5, 0, acc);
    send(8'hA1, 0, acc);
    w.a = 8'h40; w.d = 8'hA1; w.c = acc;
    wq.push_back(w);
    send(8'hA2, 0, acc);
    w.a = 8'h41; w.d = 8'hA2; w.c = acc;
    wq.push_back(w);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values();
    rst = 1'b0;
    d = '{8'h5A, SYNC, 8'hC3};
    send_frame(8'h80, 8'd3, d, 1'b1, 1);

    // Randomized frames with random gaps and checksum errors
    for (int f = 0; f < 30; f++) begin
      n = ($urandom_range(9, 0) == 0) ? 256 : $urandom_range(40, 1);
      d.delete();
      for (int i = 0; i < int'(n); i++) d.push_back(8'($urandom));
      send_frame(8'($urandom), 8'(n), d, ($urandom_range(3, 0) != 0), 2);
    end

    repeat (6) @(posedge clk);
    #1;
    check("write_queue_drained", wq.size(), 32'd0);
    check("status_queue_drained", sq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uk_table_loader.md
Name: uk_table_loader

Overview:
- Write-side counterpart of the 256x8 membership/coefficient lookup tables (Uk-family) used by the speech-processing datapath.
- Accepts a framed byte stream over a valid/ready handshake and issues registered single-byte writes into a writable table: start address, count, data, checksum.
- Reports completion/error status to the host sequencer; the read side of the table is unchanged.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT, 1024, idle cycles allowed mid-frame before abort (min 2)
- TO_W, 11, timeout counter width, must hold TIMEOUT

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
- tbl_we  out  1  table write strobe, one cycle per data byte
- tbl_addr  out  8  table write address
- tbl_wdata  out  8  table write data
- busy  out  1  frame in progress (state not IDLE)
- done  out  1  one-cycle pulse: frame ended with good checksum
- err  out  1  one-cycle pulse: bad checksum or timeout
- words_written  out  9  data bytes written in the last/current frame (0..256)

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; in_ready=0, tbl_we=0, tbl_addr=0, tbl_wdata=0, busy=0, done=0, err=0, words_written=0, checksum accumulator=0, timeout counter=0. Reset mid-frame aborts without done/err; any write already issued stays in the table.
- Frame layout: SYNC_BYTE, ADDR, CNT, CNT data bytes (CNT=0 means 256), CHK. CHK must equal the 8-bit sum mod 256 of ADDR + CNT + all data bytes.
- States:
  - IDLE: bytes other than SYNC_BYTE are accepted and discarded. SYNC -> GET_ADDR.
  - GET_ADDR: load address pointer and checksum = byte -> GET_CNT.
  - GET_CNT: load remaining = (byte==0 ? 256 : byte) as 9-bit, add to checksum, clear words_written -> DATA.
  - DATA: per accepted byte, next cycle tbl_we=1 with tbl_addr = pointer and tbl_wdata = byte. Pointer increments mod 256 (wraps 255->0). Checksum += byte, words_written++, remaining--. When remaining reaches 0 -> GET_CHK.
  - GET_CHK: compare byte to checksum -> STATUS.
  - STATUS: one cycle, done=1 (match) or err=1 (mismatch), in_ready=0 -> IDLE.
- in_ready=1 in IDLE, GET_ADDR, GET_CNT, DATA, GET_CHK; 0 in STATUS and during reset. There is no back-pressure from the table, so a byte per cycle is sustained.
- Write latency: exactly 1 cycle from accepted data byte to tbl_we. tbl_we is 0 in all other cycles. tbl_addr and tbl_wdata hold their last values when tbl_we=0.
- Data is written as it arrives. A bad checksum does not roll back the table; the host reloads.
- Timeout:
  - Counter runs in every non-IDLE, non-STATUS state in cycles without a transfer; it clears on any transfer.
  - Reaching TIMEOUT -> STATUS with err=1.
- SYNC_BYTE inside a frame is treated as ordinary data, no resync.
- busy=1 from the cycle after SYNC is accepted through the STATUS cycle inclusive.
- words_written holds its value after the frame until the next GET_CNT.

Decomposition:
- Shared package uk_pkg: state enum (IDLE, GET_ADDR, GET_CNT, DATA, GET_CHK, STATUS), SYNC_BYTE default, table depth constant 256, address/data width constants 8.
- One natural sub-module: uk_loader_timeout (loadable idle counter, clear on transfer, terminal-count flag). Everything else stays in one FSM module.

Test Plan:
- Frame A5,10,03,11,22,33,CHK=0x79 at one byte/cycle -> writes (10,11),(11,22),(12,33) on consecutive cycles, each 1 cycle after acceptance; done pulse; words_written=3.
- Frame A5,FE,04,01,02,03,04,CHK=0x0C -> addresses FE,FF,00,01 (wrap); done=1.
- CNT=00 with 256 bytes of 0x02, CHK = (ADDR+0+0x200) mod 256 = ADDR -> 256 writes; words_written=256; done.
- Same as scenario 1 but CHK=0x78 -> 3 writes still occur; err pulse; done stays 0.
- Garbage 00,FF before SYNC -> no writes, busy=0. Mid-frame stall of TIMEOUT cycles after 1 data byte -> err pulse, return to IDLE, in_ready=0 for exactly the STATUS cycle.
- rst asserted in DATA after 2 writes -> next cycle all outputs at reset values; no done/err; a following good frame loads normally.
